// File: rtl/control_unit.sv
// Main control decoder for the MIPS-subset datapath: decodes op/func into
// register-file, memory, branch, operand-select and ALU controls, all registered.
module control_unit (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] func,
    input  logic [5:0] op,
    output logic       WriteReg,
    output logic       MemToReg,
    output logic       writeMem,
    output logic       Branch,
    output logic       Regrt,
    output logic [2:0] ALUC,
    output logic       ALUImm
);

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_ADD = 6'd32;
    localparam logic [5:0] FN_SUB = 6'd34;
    localparam logic [5:0] FN_AND = 6'd36;
    localparam logic [5:0] FN_OR  = 6'd37;
    localparam logic [5:0] FN_NOR = 6'd39;
    localparam logic [5:0] FN_SLT = 6'd42;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    logic       write_reg_s;
    logic       mem_to_reg_s;
    logic       write_mem_s;
    logic       branch_s;
    logic       regrt_s;
    logic [2:0] aluc_s;
    logic       alu_imm_s;
    logic       rtype_valid_s;
    logic [2:0] rtype_aluc_s;

    // R-type function field to ALU code; unknown funcs are treated as NOP
    always_comb begin
        rtype_valid_s = 1'b1;
        rtype_aluc_s  = 3'b000;
        case (func)
            FN_ADD:  rtype_aluc_s = ALU_ADD;
            FN_SUB:  rtype_aluc_s = ALU_SUB;
            FN_AND:  rtype_aluc_s = ALU_AND;
            FN_OR:   rtype_aluc_s = ALU_OR;
            FN_NOR:  rtype_aluc_s = ALU_NOR;
            FN_SLT:  rtype_aluc_s = ALU_SLT;
            default: rtype_valid_s = 1'b0;
        endcase
    end

    // Opcode decode; anything not listed falls through to the all-zero NOP vector
    always_comb begin
        write_reg_s  = 1'b0;
        mem_to_reg_s = 1'b0;
        write_mem_s  = 1'b0;
        branch_s     = 1'b0;
        regrt_s      = 1'b0;
        aluc_s       = 3'b000;
        alu_imm_s    = 1'b0;
        case (op)
            OP_RTYPE: begin
                if (rtype_valid_s) begin
                    write_reg_s = 1'b1;
                    aluc_s      = rtype_aluc_s;
                end else begin
                    write_reg_s = 1'b0;
                    aluc_s      = 3'b000;
                end
            end
            OP_LW: begin
                write_reg_s  = 1'b1;
                mem_to_reg_s = 1'b1;
                regrt_s      = 1'b1;
                alu_imm_s    = 1'b1;
                aluc_s       = ALU_ADD;
            end
            OP_SW: begin
                write_mem_s = 1'b1;
                regrt_s     = 1'b1;
                alu_imm_s   = 1'b1;
                aluc_s      = ALU_ADD;
            end
            OP_BEQ: begin
                branch_s = 1'b1;
                aluc_s   = ALU_SUB;
            end
            default: begin
                write_reg_s = 1'b0;
            end
        endcase
    end

    // Output register stage, cleared asynchronously while rst is low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WriteReg <= 1'b0;
            MemToReg <= 1'b0;
            writeMem <= 1'b0;
            Branch   <= 1'b0;
            Regrt    <= 1'b0;
            ALUC     <= 3'b000;
            ALUImm   <= 1'b0;
        end else begin
            WriteReg <= write_reg_s;
            MemToReg <= mem_to_reg_s;
            writeMem <= write_mem_s;
            Branch   <= branch_s;
            Regrt    <= regrt_s;
            ALUC     <= aluc_s;
            ALUImm   <= alu_imm_s;
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit; observed vector is
// {WriteReg, MemToReg, writeMem, Branch, Regrt, ALUImm, ALUC[2:0]}.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [5:0] func;
    logic [5:0] op;
    logic       WriteReg;
    logic       MemToReg;
    logic       writeMem;
    logic       Branch;
    logic       Regrt;
    logic [2:0] ALUC;
    logic       ALUImm;
    logic [8:0] obs;

    int total;
    int bad;

    localparam logic [8:0] V_ZERO = 9'b000000_000;
    localparam logic [8:0] V_LW   = 9'b110011_010;
    localparam logic [8:0] V_SW   = 9'b001011_010;
    localparam logic [8:0] V_BEQ  = 9'b000100_110;

    control_unit dut (
        .clk      (clk),
        .rst      (rst),
        .func     (func),
        .op       (op),
        .WriteReg (WriteReg),
        .MemToReg (MemToReg),
        .writeMem (writeMem),
        .Branch   (Branch),
        .Regrt    (Regrt),
        .ALUC     (ALUC),
        .ALUImm   (ALUImm)
    );

    assign obs = {WriteReg, MemToReg, writeMem, Branch, Regrt, ALUImm, ALUC};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; op = 6'd0; func = 6'd32;
        #2;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL reset_async got=%b exp=%b", obs, V_ZERO); end
        for (int i = 0; i < 3; i++) begin
            step();
            total++;
            if (obs !== V_ZERO) begin bad++; $display("FAIL reset_hold%0d got=%b exp=%b", i, obs, V_ZERO); end
        end
        rst = 1'b1;
        #1;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL reset_release_noedge got=%b exp=%b", obs, V_ZERO); end
        step();
        total++;
        if (obs !== 9'b100000_010) begin bad++; $display("FAIL reset_first_decode got=%b exp=%b", obs, 9'b100000_010); end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL reset_midcycle got=%b exp=%b", obs, V_ZERO); end
        step();
        rst = 1'b1;
    endtask

    task automatic test_rtype();
        logic [5:0] fn_tab [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};
        logic [8:0] ex_tab [6] = '{9'b100000_010, 9'b100000_110, 9'b100000_000,
                                   9'b100000_001, 9'b100000_100, 9'b100000_111};
        op = 6'd0;
        for (int i = 0; i < 6; i++) begin
            func = fn_tab[i];
            for (int c = 0; c < 2; c++) begin
                step();
                total++;
                if (obs !== ex_tab[i]) begin
                    bad++;
                    $display("FAIL rtype_func%0d_c%0d got=%b exp=%b", fn_tab[i], c, obs, ex_tab[i]);
                end
            end
        end
    endtask

    task automatic test_nop();
        op = 6'd0; func = 6'd0;
        step();
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL nop_func0 got=%b exp=%b", obs, V_ZERO); end
        func = 6'd33;
        step();
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL nop_func33 got=%b exp=%b", obs, V_ZERO); end
    endtask

    task automatic test_load();
        op = 6'd35; func = 6'd0;
        step();
        total++;
        if (obs !== V_LW) begin bad++; $display("FAIL load got=%b exp=%b", obs, V_LW); end
        func = 6'd34;
        step();
        total++;
        if (obs !== V_LW) begin bad++; $display("FAIL load_func_ignored got=%b exp=%b", obs, V_LW); end
    endtask

    task automatic test_store_branch();
        op = 6'd43; func = 6'd0;
        step();
        total++;
        if (obs !== V_SW) begin bad++; $display("FAIL store got=%b exp=%b", obs, V_SW); end
        op = 6'd4; func = 6'd42;
        step();
        total++;
        if (obs !== V_BEQ) begin bad++; $display("FAIL branch got=%b exp=%b", obs, V_BEQ); end
    endtask

    task automatic test_latency();
        op = 6'd35; func = 6'd0;
        step();
        total++;
        if (obs !== V_LW) begin bad++; $display("FAIL latency_lw got=%b exp=%b", obs, V_LW); end
        op = 6'd43;
        #3;
        total++;
        if (obs !== V_LW) begin bad++; $display("FAIL latency_hold got=%b exp=%b", obs, V_LW); end
        step();
        total++;
        if (obs !== V_SW) begin bad++; $display("FAIL latency_sw got=%b exp=%b", obs, V_SW); end
        op = 6'd63; func = 6'd32;
        step();
        total++;
        if (obs !== V_ZERO) begin bad++; $display("FAIL unlisted_op63 got=%b exp=%b", obs, V_ZERO); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        op    = 6'd0;
        func  = 6'd0;
        test_reset();
        test_rtype();
        test_nop();
        test_load();
        test_store_branch();
        test_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
